// File: rtl/restoring_divider_8bit.sv
// Purpose: 8-bit by 6-bit unsigned restoring divider with divide-by-zero flagging.
// Latency: done pulses 9 cycles after an accepted start (1 cycle when divisor is 0).
// Backpressure: start is only honoured in IDLE; requests while busy or finishing are dropped.
module restoring_divider_8bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [5:0] divisor,
  output logic [7:0] quotient,
  output logic [5:0] remainder,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic [2:0] cnt;    // remaining restoring steps, counts 7 down to 0
  logic [7:0] shreg;  // dividend bits leave at the MSB, quotient bits enter at the LSB
  logic [5:0] rem;    // running partial remainder
  logic [5:0] dvs;    // captured divisor

  logic [6:0] partial;
  logic       ge;
  logic [5:0] diff;

  // One restoring step: bring down the next dividend bit and try to subtract.
  // When the subtraction succeeds the true difference is below the divisor,
  // so the low six bits of the modular difference are exact.
  always_comb begin
    partial = {rem, shreg[7]};
    ge      = (partial >= {1'b0, dvs});
    diff    = partial[5:0] - dvs;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state selection; zero divisors skip straight to FINISH.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (divisor == 6'd0) ? FINISH : RUN;
        end
      end
      RUN: begin
        if (cnt == 3'd0) begin
          state_nxt = FINISH;
        end
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy = (state == RUN);

  // Datapath: operand capture, iterative steps, and result register load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= 3'd0;
      shreg       <= 8'd0;
      rem         <= 6'd0;
      dvs         <= 6'd0;
      quotient    <= 8'd0;
      remainder   <= 6'd0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg       <= dividend;
            dvs         <= divisor;
            rem         <= 6'd0;
            cnt         <= 3'd7;
            div_by_zero <= 1'b0;
          end
        end
        RUN: begin
          rem   <= ge ? diff : partial[5:0];
          shreg <= {shreg[6:0], ge};
          cnt   <= cnt - 3'd1;
        end
        FINISH: begin
          done <= 1'b1;
          if (dvs == 6'd0) begin
            quotient    <= 8'hFF;
            remainder   <= 6'h3F;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= shreg;
            remainder   <= rem;
          end
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule
